dense_layer_seq: RTL
====================

# dense_layer_seq

Runtime-configurable, fully parametrised fixed-point dense (fully connected) layer engine. It replaces per-layer constant weight/bias packages with a loadable register file. It consumes one input activation per handshake, updates N_OUT parallel accumulators, then streams N_OUT saturated (optionally ReLU'd) outputs. It sits between adjacent layers in the manual network datapath and shares their valid/ready streaming convention.

## Interface
- N_IN, 32, input activations per frame (≥2)
- N_OUT, 5, output neurons / parallel MACs (≥1)
- WIDTH, 17, signed two's-complement width of activations, weights, biases and outputs
- NFRAC, 8, fractional bits, common to all operands
- RELU, 0, 1 = clamp negative outputs to 0
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  parameter write strobe
- wr_addr  in  $clog2(N_IN*N_OUT+N_OUT)  0..N_IN*N_OUT-1 = weight[i][j] at i*N_OUT+j; N_IN*N_OUT+j = bias[j]
- wr_data  in  WIDTH  parameter value
- cfg_busy  out  1  1 = frame in progress, writes ignored
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  WIDTH  activation x[i], i implied by arrival order
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  WIDTH  y[j], j implied by order
- out_last  out  1  high on beat j = N_OUT-1

## Operation
- States: ACC (accepting inputs), OUT (streaming results). Reset state ACC.
- Counters: in_cnt 0..N_IN-1, out_cnt 0..N_OUT-1.
- ACC, on in_valid&&in_ready:
  - in_cnt==0: acc[j] <= (bias[j] <<< NFRAC) + x*w[0][j]
  - else: acc[j] <= acc[j] + x*w[in_cnt][j]
  - in_cnt==N_IN-1: in_cnt <= 0, go to OUT.
- Accumulator width: 2*WIDTH + $clog2(N_IN) + 1, sign-extended. No intermediate overflow.
- Result r[j]: acc[j] >>> NFRAC (arithmetic shift, truncate toward −inf), saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. If RELU, negative values become 0.
- OUT: out_data = r[out_cnt]. On out_valid&&out_ready, out_cnt increments. On the last beat, out_cnt <= 0 and state returns to ACC.
- Parameter writes: applied when wr_en && !cfg_busy. Addresses ≥ N_IN*N_OUT+N_OUT are ignored.
- cfg_busy = (state==OUT) || (in_cnt!=0).
- Writes arriving while cfg_busy is high are dropped silently and never queued. A write on the same cycle as the first input beat is dropped because cfg_busy is already deasserted? No: with cfg_busy low, the write applies, and the MAC for that cycle uses the pre-write value.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, cfg_busy=0, all weights/biases/accumulators=0, counters=0.
- in_ready = (state==ACC). out_valid = (state==OUT). out_data and out_last are driven from registered acc and out_cnt.
- Frame latency: the last input accepted at cycle t gives out_valid=1 with y[0] at cycle t+1.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.
- in_ready rises the cycle after the out_last handshake. There is no input/output overlap (half-duplex).
- Minimum frame period: N_IN + N_OUT cycles.
- Asynchronous reset mid-frame or mid-output aborts the frame: partial accumulations and pending outputs are lost, and parameters are cleared.

## Test plan
- Basic MAC: w[0][0]=256, bias[0]=128, all other params 0; inputs x0=512, x1..x31=0 -> outputs 640,0,0,0,0, with out_last on the 5th beat.
- Saturation/sign: all w=256, inputs all 65535 -> y=65535 for every j. Inputs all −65536 -> y=−65536. Bias 0 for both.
- ReLU/truncation: RELU=1, w[0][0]=−256, x0=300 -> y0=0. With RELU=0, w[0][0]=−1, x0=1 -> y0=−1 (−1/256 floors).
- Backpressure: hold out_ready=0 for 3 cycles on beat 2 -> out_data stable; in_ready stays 0 until the final handshake.
- Write gating: mid-frame (in_cnt=10) write bias[1]=1000 -> ignored, output matches the golden model without it. The same write with cfg_busy=0 takes effect on the next frame.
- Reset mid-frame: assert rst_n=0 at in_cnt=15, release, send a full frame without reloading -> all outputs 0. Reload params -> the next frame matches the golden model.

Source files
------------

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: fixed-point dense layer with a loadable weight/bias file.
// Accumulates one activation per beat into N_OUT MACs, then streams results.
module dense_layer_seq #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 5,
  parameter int WIDTH = 17,
  parameter int NFRAC = 8,
  parameter int RELU  = 0,
  localparam int AW = $clog2(N_IN*N_OUT+N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             cfg_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  localparam int NW   = N_IN*N_OUT;
  localparam int CW   = $clog2(N_IN);
  localparam int OW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW   = 2*WIDTH;
  localparam int ACCW = PW + CW + 1;
  localparam logic signed [ACCW-1:0] SMAX = ACCW'(2**(WIDTH-1)-1);
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

  typedef enum logic {ACC, OUT} state_t;

  state_t state;
  logic [CW-1:0] in_cnt;
  logic [OW-1:0] out_cnt;

  logic signed [WIDTH-1:0] wmem [NW];
  logic signed [WIDTH-1:0] bias [N_OUT];
  logic signed [ACCW-1:0]  acc  [N_OUT];

  logic signed [WIDTH-1:0] wsel [N_OUT];
  logic [PW-1:0]           xe;
  logic [PW-1:0]           we   [N_OUT];
  logic signed [PW-1:0]    prod [N_OUT];
  logic [ACCW-1:0]         base [N_OUT];
  logic signed [ACCW-1:0]  nxt  [N_OUT];
  logic signed [ACCW-1:0]  sh   [N_OUT];
  logic [WIDTH-1:0]        res  [N_OUT];

  logic in_fire;
  logic out_fire;
  logic wr_ok;
  logic last_in;
  logic last_out;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign cfg_busy  = (state == OUT) || (in_cnt != '0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_ok     = wr_en && !cfg_busy;
  assign last_in   = (in_cnt == CW'(N_IN-1));
  assign last_out  = (out_cnt == OW'(N_OUT-1));
  assign out_last  = out_valid && last_out;
  assign xe        = {{WIDTH{in_data[WIDTH-1]}}, in_data};

  // Row select for the current input index, then one MAC per neuron.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      wsel[j] = '0;
      for (int i = 0; i < N_IN; i++)
        if (int'(in_cnt) == i) wsel[j] = wmem[i*N_OUT+j];
      we[j]   = {{WIDTH{wsel[j][WIDTH-1]}}, wsel[j]};
      prod[j] = signed'(xe * we[j]);
      if (in_cnt == '0)
        base[j] = {{(ACCW-WIDTH){bias[j][WIDTH-1]}}, bias[j]} << NFRAC;
      else
        base[j] = acc[j];
      nxt[j] = signed'(base[j]
             + {{(ACCW-PW){prod[j][PW-1]}}, prod[j]});
    end
  end

  // Floor-rescale, saturate, optional ReLU.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      sh[j] = acc[j] >>> NFRAC;
      if (sh[j] > SMAX)
        res[j] = SMAX[WIDTH-1:0];
      else if (sh[j] < SMIN)
        res[j] = SMIN[WIDTH-1:0];
      else
        res[j] = sh[j][WIDTH-1:0];
      if (RELU != 0 && sh[j] < 0)
        res[j] = '0;
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N_OUT; j++)
      if (int'(out_cnt) == j) out_data = res[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      in_cnt  <= '0;
      out_cnt <= '0;
      for (int k = 0; k < NW; k++)
        wmem[k] <= '0;
      for (int j = 0; j < N_OUT; j++) begin
        bias[j] <= '0;
        acc[j]  <= '0;
      end
    end else begin
      if (wr_ok) begin
        for (int k = 0; k < NW; k++)
          if (int'(wr_addr) == k) wmem[k] <= wr_data;
        for (int j = 0; j < N_OUT; j++)
          if (int'(wr_addr) == NW + j) bias[j] <= wr_data;
      end
      case (state)
        ACC: begin
          if (in_fire) begin
            for (int j = 0; j < N_OUT; j++)
              acc[j] <= nxt[j];
            if (last_in) begin
              in_cnt <= '0;
              state  <= OUT;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_fire) begin
            if (last_out) begin
              out_cnt <= '0;
              state   <= ACC;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
